// File: rtl/weakcore_v2.sv
// weakcore_v2: multi-cycle RV32I/RV32E core, sole master of a shared req/ack memory bus.
// Latency: ALU/branch/jump 3 cycles, load/store 4 cycles with zero-wait ack; +1 per wait cycle.
// Backpressure: bus signals held stable in FETCH/MEM until bus_ack; HALT is terminal until rst.
module weakcore_v2 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      bus_in,
    output logic [31:0]      bus_out,
    output logic [31:0]      bus_addr,
    output logic             bus_req,
    input  logic             bus_ack,
    output logic             bus_wr,
    output logic [3:0]       bus_wr_mask,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [31:0]      halt_pc,
    output logic [CNT_W-1:0] instret
);
    localparam int RA_W = (NREGS == 16) ? 4 : 5;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, instr_q, ipc_q, ld_q, hpc_q;
    logic [2:0]         cause_q;
    logic [CNT_W-1:0]   instret_q;
    logic [31:0]        rf_q [NREGS];

    // Instruction fields and immediates
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign opc   = instr_q[6:0];
    assign rd    = instr_q[11:7];
    assign f3    = instr_q[14:12];
    assign rs1   = instr_q[19:15];
    assign rs2   = instr_q[24:20];
    assign f7    = instr_q[31:25];
    assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    assign imm_u = {instr_q[31:12], 12'h000};
    assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    logic is_jal, is_jalr, is_br, is_ld, is_st, is_op, is_ecall, is_ebreak;
    assign is_jal    = (opc == OP_JAL);
    assign is_jalr   = (opc == OP_JALR);
    assign is_br     = (opc == OP_BR);
    assign is_ld     = (opc == OP_LD);
    assign is_st     = (opc == OP_ST);
    assign is_op     = (opc == OP_REG);
    assign is_ecall  = (instr_q == 32'h0000_0073);
    assign is_ebreak = (instr_q == 32'h0010_0073);

    logic use_rd, use_rs1, use_rs2;
    assign use_rd  = (opc == OP_LUI) || (opc == OP_AUIPC) || is_jal || is_jalr || is_ld ||
                     (opc == OP_IMM) || is_op;
    assign use_rs1 = is_jalr || is_br || is_ld || is_st || (opc == OP_IMM) || is_op;
    assign use_rs2 = is_br || is_st || is_op;

    // Operand read; x0 is hardwired to zero
    logic [31:0] rv1, rv2;
    assign rv1 = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1[RA_W-1:0]];
    assign rv2 = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2[RA_W-1:0]];

    // Legality: only base RV32I encodings; RV32E also rejects register indices >= 16
    logic legal;
    always_comb begin
        legal = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
            OP_JALR:  legal = (f3 == 3'd0);
            OP_BR:    legal = (f3 != 3'd2) && (f3 != 3'd3);
            OP_LD:    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            OP_ST:    legal = (f3 <= 3'd2);
            OP_IMM: begin
                if (f3 == 3'd1)      legal = (f7 == 7'h00);
                else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                 legal = 1'b1;
            end
            OP_REG:   legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            OP_FENCE: legal = (f3 == 3'd0);
            OP_SYS:   legal = is_ecall || is_ebreak;
            default:  legal = 1'b0;
        endcase
        if ((NREGS == 16) && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
            legal = 1'b0;
    end

    // ALU for OP and OP-IMM; compares are true 33-bit signed/unsigned
    logic [31:0] opb, alu;
    logic [4:0]  shamt;
    always_comb begin
        opb   = is_op ? rv2 : imm_i;
        shamt = opb[4:0];
        case (f3)
            3'd0:    alu = (is_op && f7[5]) ? (rv1 - opb) : (rv1 + opb);
            3'd1:    alu = rv1 << shamt;
            3'd2:    alu = {31'h0, $signed(rv1) < $signed(opb)};
            3'd3:    alu = {31'h0, rv1 < opb};
            3'd4:    alu = rv1 ^ opb;
            3'd5:    alu = f7[5] ? 32'($signed(rv1) >>> shamt) : (rv1 >> shamt);
            3'd6:    alu = rv1 | opb;
            default: alu = rv1 & opb;
        endcase
    end

    // Branch decision and next-pc selection
    logic        br_cond, jump;
    logic [31:0] tgt, jalr_sum;
    assign jalr_sum = rv1 + imm_i;
    always_comb begin
        case (f3)
            3'd0:    br_cond = (rv1 == rv2);
            3'd1:    br_cond = (rv1 != rv2);
            3'd4:    br_cond = $signed(rv1) <  $signed(rv2);
            3'd5:    br_cond = $signed(rv1) >= $signed(rv2);
            3'd6:    br_cond = rv1 <  rv2;
            3'd7:    br_cond = rv1 >= rv2;
            default: br_cond = 1'b0;
        endcase
        jump = 1'b0;
        tgt  = ipc_q + 32'd4;
        if (is_jal) begin
            jump = 1'b1;
            tgt  = ipc_q + imm_j;
        end else if (is_jalr) begin
            jump = 1'b1;
            tgt  = {jalr_sum[31:1], 1'b0};
        end else if (is_br && br_cond) begin
            jump = 1'b1;
            tgt  = ipc_q + imm_b;
        end
    end

    // Effective address and alignment of the memory access
    logic [31:0] eaddr;
    logic        mis;
    assign eaddr = rv1 + (is_st ? imm_s : imm_i);
    assign mis   = ((f3[1:0] == 2'd1) && eaddr[0]) || ((f3[1:0] == 2'd2) && (eaddr[1:0] != 2'd0));

    // Trap detection in EXEC, highest priority first
    logic       fault;
    logic [2:0] fcause;
    always_comb begin
        fault  = 1'b1;
        fcause = 3'd0;
        if (!legal)                          fcause = 3'd1;
        else if (is_ecall)                   fcause = 3'd5;
        else if (is_ebreak)                  fcause = 3'd0;
        else if (jump && (tgt[1:0] != 2'd0)) fcause = 3'd2;
        else if (is_ld && mis)               fcause = 3'd3;
        else if (is_st && mis)               fcause = 3'd4;
        else                                 fault  = 1'b0;
    end

    // Load lane select and extension
    logic [31:0] ld_sh, ld_ext;
    assign ld_sh = bus_in >> {eaddr[1:0], 3'b000};
    always_comb begin
        case (f3)
            3'd0:    ld_ext = {{24{ld_sh[7]}}, ld_sh[7:0]};
            3'd1:    ld_ext = {{16{ld_sh[15]}}, ld_sh[15:0]};
            3'd4:    ld_ext = {24'h0, ld_sh[7:0]};
            3'd5:    ld_ext = {16'h0, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    // Register write-back value
    logic [31:0] wb_val;
    logic        rf_we;
    always_comb begin
        case (opc)
            OP_LUI:          wb_val = imm_u;
            OP_AUIPC:        wb_val = ipc_q + imm_u;
            OP_JAL, OP_JALR: wb_val = ipc_q + 32'd4;
            OP_LD:           wb_val = ld_q;
            default:         wb_val = alu;
        endcase
    end
    assign rf_we = (state_q == S_WB) && use_rd && (rd != 5'd0) && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (bus_ack) state_d = S_EXEC;
            S_EXEC: begin
                if (fault)               state_d = S_HALT;
                else if (is_ld || is_st) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM:   if (bus_ack) state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    // Bus outputs, all forced quiet while rst is high
    always_comb begin
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_wr_mask = 4'h0;
        bus_out     = 32'h0;
        bus_addr    = {pc_q[31:2], 2'b00};
        if (!rst) begin
            case (state_q)
                S_FETCH: bus_req = 1'b1;
                S_MEM: begin
                    bus_req  = 1'b1;
                    bus_addr = {eaddr[31:2], 2'b00};
                    bus_wr   = is_st;
                    bus_out  = rv2 << {eaddr[1:0], 3'b000};
                    if (is_st) begin
                        case (f3[1:0])
                            2'd0:    bus_wr_mask = 4'b0001 << eaddr[1:0];
                            2'd1:    bus_wr_mask = 4'b0011 << eaddr[1:0];
                            default: bus_wr_mask = 4'b1111;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers: pc, latched instruction, load data, trap info, instret
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            instret_q <= '0;
            cause_q   <= 3'd0;
            hpc_q     <= 32'h0;
        end else begin
            case (state_q)
                S_FETCH: if (bus_ack) begin
                    instr_q <= bus_in;
                    ipc_q   <= pc_q;
                end
                S_EXEC: if (fault) begin
                    cause_q <= fcause;
                    hpc_q   <= ipc_q;
                end
                S_MEM: if (bus_ack && is_ld) ld_q <= ld_ext;
                S_WB: begin
                    pc_q      <= tgt;
                    instret_q <= instret_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Register file write port (contents are never reset)
    always_ff @(posedge clk) begin
        if (rf_we) rf_q[rd[RA_W-1:0]] <= wb_val;
    end

    assign halted     = (state_q == S_HALT);
    assign halt_cause = cause_q;
    assign halt_pc    = hpc_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_weakcore_v2.sv
// Directed bench for weakcore_v2: RV32I instance on a wait-state memory, RV32E instance on a ROM.
// Checks cycle-exact latency, bus fields, stored results, traps and reset recovery.
module tb_weakcore_v2;
    logic        clk, rst;
    logic [31:0] bin0, out0, addr0, hpc0, ir0;
    logic        req0, ack0, wr0, hlt0;
    logic [3:0]  msk0;
    logic [2:0]  hc0;
    logic [31:0] bin1, out1, addr1, hpc1, ir1;
    logic        req1, ack1, wr1, hlt1;
    logic [3:0]  msk1;
    logic [2:0]  hc1;

    logic [31:0] rom0 [64];
    logic [31:0] ram0 [256];
    logic [31:0] rom1 [4];
    logic        ram_clr;
    logic [3:0]  wait_n, wcnt;
    int          dcnt;
    int          n_chk, n_fail;

    weakcore_v2 #(.RESET_PC(32'h0), .NREGS(32), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .bus_in(bin0), .bus_out(out0), .bus_addr(addr0),
        .bus_req(req0), .bus_ack(ack0), .bus_wr(wr0), .bus_wr_mask(msk0),
        .halted(hlt0), .halt_cause(hc0), .halt_pc(hpc0), .instret(ir0));

    weakcore_v2 #(.RESET_PC(32'h0), .NREGS(16), .CNT_W(32)) u_e (
        .clk(clk), .rst(rst), .bus_in(bin1), .bus_out(out1), .bus_addr(addr1),
        .bus_req(req1), .bus_ack(ack1), .bus_wr(wr1), .bus_wr_mask(msk1),
        .halted(hlt1), .halt_cause(hc1), .halt_pc(hpc1), .instret(ir1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ROM below 0x100, RAM above; ack after wait_n wait cycles
    assign ack0 = req0 && (wcnt == wait_n);
    assign bin0 = (addr0[9:8] == 2'b00) ? rom0[addr0[7:2]] : ram0[addr0[9:2]];
    assign ack1 = req1;
    assign bin1 = rom1[addr1[3:2]];

    always @(posedge clk) begin
        if (req0 && !ack0) wcnt <= wcnt + 4'd1;
        else               wcnt <= 4'd0;
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram0[i] <= 32'h0;
            dcnt <= 0;
        end else if (req0 && ack0 && (addr0[9:8] != 2'b00)) begin
            dcnt <= dcnt + 1;
            if (wr0)
                for (int b = 0; b < 4; b++)
                    if (msk0[b]) ram0[addr0[9:2]][8*b +: 8] <= out0[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; ram_clr = 1'b1; wait_n = 4'd0; wcnt = 4'd0;
        for (int i = 0; i < 64; i++) rom0[i] = 32'h0000_0013;
        rom0[0]  = 32'h0050_0093; // ADDI x1,x0,5
        rom0[1]  = 32'hFF90_8113; // ADDI x2,x1,-7
        rom0[2]  = 32'h2020_2023; // SW   x2,0x200(x0)
        rom0[3]  = 32'h0011_7463; // BGEU x2,x1,+8
        rom0[4]  = 32'h0010_0193; // ADDI x3,x0,1 (skipped)
        rom0[5]  = 32'h0011_5463; // BGE  x2,x1,+8 (not taken)
        rom0[6]  = 32'h1030_0213; // ADDI x4,x0,0x103
        rom0[7]  = 32'h0AB0_0293; // ADDI x5,x0,0xAB
        rom0[8]  = 32'h0052_0023; // SB   x5,0(x4)
        rom0[9]  = 32'h0002_0303; // LB   x6,0(x4)
        rom0[10] = 32'h2060_2223; // SW   x6,0x204(x0)
        rom0[11] = 32'h4020_83B3; // SUB  x7,x1,x2
        rom0[12] = 32'h2070_2423; // SW   x7,0x208(x0)
        rom0[13] = 32'h0080_056F; // JAL  x10,+8
        rom0[14] = 32'h0010_0073; // EBREAK (skipped)
        rom0[15] = 32'h20A0_2623; // SW   x10,0x20C(x0)
        rom0[16] = 32'h1020_2583; // LW   x11,0x102(x0) -> misaligned
        rom1[0]  = 32'h0010_0093; // ADDI x1,x0,1
        rom1[1]  = 32'h0020_88B3; // ADD  x17,x1,x2 -> illegal on RV32E
        rom1[2]  = 32'h0000_0013;
        rom1[3]  = 32'h0000_0013;

        tick(2);
        ram_clr = 1'b0;
        chk("rst_halted", {31'h0, hlt0}, 32'h0);
        chk("rst_instret", ir0, 32'h0);
        chk("rst_req", {31'h0, req0}, 32'h0);
        chk("rst_cause", {29'h0, hc0}, 32'h0);
        chk("rst_hpc", hpc0, 32'h0);
        chk("rst_wr_mask", {27'h0, wr0, msk0}, 32'h0);

        rst = 1'b0; #1;
        chk("fetch0_req", {31'h0, req0}, 32'h1);
        chk("fetch0_addr", addr0, 32'h0);
        tick(5);
        chk("instret_5cyc", ir0, 32'd1);
        tick(1);
        chk("instret_6cyc", ir0, 32'd2);

        tick(2); // SW x2 in MEM
        chk("sw_addr", addr0, 32'h200);
        chk("sw_wr", {31'h0, wr0}, 32'h1);
        chk("sw_mask", {28'h0, msk0}, 32'hF);
        chk("sw_data_x2", out0, 32'hFFFF_FFFE);
        tick(2);
        chk("sw_instret", ir0, 32'd3);

        tick(3);
        chk("bgeu_taken", addr0, 32'h14);
        tick(3);
        chk("bge_not_taken", addr0, 32'h18);
        tick(6);
        tick(2); // SB in MEM
        chk("sb_addr", addr0, 32'h100);
        chk("sb_mask", {28'h0, msk0}, 32'h8);
        chk("sb_byte", {24'h0, out0[31:24]}, 32'hAB);
        tick(2);
        tick(4); // LB
        tick(2); // SW x6 in MEM
        chk("lb_sext", out0, 32'hFFFF_FFAB);
        tick(2);
        tick(3); // SUB
        tick(2); // SW x7 in MEM
        chk("sub_res", out0, 32'h7);
        tick(2);
        tick(3); // JAL
        chk("jal_target", addr0, 32'h3C);
        tick(2); // SW x10 in MEM
        chk("jal_link", out0, 32'h38);
        tick(2);
        tick(2); // LW misaligned
        chk("lw_mis_halted", {31'h0, hlt0}, 32'h1);
        chk("lw_mis_cause", {29'h0, hc0}, 32'd3);
        chk("lw_mis_hpc", hpc0, 32'h40);
        tick(2);
        chk("halt_req", {31'h0, req0}, 32'h0);
        chk("halt_instret", ir0, 32'd14);
        chk("halt_no_mem", dcnt, 32'd6);
        chk("ram_200", ram0[8'h80], 32'hFFFF_FFFE);
        chk("ram_100", ram0[8'h40], 32'hAB00_0000);
        chk("ram_204", ram0[8'h81], 32'hFFFF_FFAB);
        chk("ram_208", ram0[8'h82], 32'h7);
        chk("ram_20c", ram0[8'h83], 32'h38);

        chk("e_halted", {31'h0, hlt1}, 32'h1);
        chk("e_cause", {29'h0, hc1}, 32'd1);
        chk("e_hpc", hpc1, 32'h4);
        chk("e_instret", ir1, 32'd1);
        chk("e_bus_quiet", {26'h0, req1, wr1, msk1} | out1, 32'h0);

        // Restart with three wait states on every access
        rst = 1'b1; #1;
        tick(1);
        chk("rst2_halted", {31'h0, hlt0}, 32'h0);
        chk("rst2_instret", ir0, 32'h0);
        wait_n = 4'd3; rst = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'h0, req0}, 32'h1);
            chk("wait_addr", addr0, 32'h0);
            chk("wait_wr", {31'h0, wr0}, 32'h0);
            if (i < 3) tick(1);
        end
        tick(2);
        chk("wait_instret_5", ir0, 32'd0);
        tick(1);
        chk("wait_instret_6", ir0, 32'd1);
        chk("wait_fetch1", addr0, 32'h4);

        // Reset mid-fetch drops the request immediately
        rst = 1'b1; #1;
        chk("rst_mid_req", {31'h0, req0}, 32'h0);
        tick(1);
        rom0[0] = 32'h0010_0073; // EBREAK
        wait_n = 4'd0; rst = 1'b0;
        tick(2);
        chk("ebreak_halted", {31'h0, hlt0}, 32'h1);
        chk("ebreak_cause", {29'h0, hc0}, 32'd0);
        chk("ebreak_hpc", hpc0, 32'h0);
        chk("ebreak_instret", ir0, 32'd0);

        rst = 1'b1;
        tick(1);
        rom0[0] = 32'h0000_0073; // ECALL
        rst = 1'b0;
        tick(2);
        chk("ecall_halted", {31'h0, hlt0}, 32'h1);
        chk("ecall_cause", {29'h0, hc0}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
